ata_target: RTL and testbench

Device-side ATA/IDE PIO responder: the drive end of the bus driven by the host IDE strobe generator. It decodes CS_n/DA with IOR_n/IOW_n, implements the task-file registers and a 256-word sector buffer, and executes READ SECTORS (0x20) and WRITE SECTORS (0x30) against a simple block-store backend port. It is used for on-board CF/flash emulation and as a synthesizable drive in system simulation.

---
 rtl/ata_pkg.sv | 35 +++
 rtl/ata_sector_buf.sv | 54 +++++
 rtl/ata_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_ata_target.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ata_pkg.sv
// Shared constants and types for the ATA PIO device-side responder.
package ata_pkg;

    localparam logic [1:0] CS_CMD = 2'b10;
    localparam logic [1:0] CS_CTL = 2'b01;

    localparam logic [2:0] DA_DATA   = 3'd0;
    localparam logic [2:0] DA_ERR    = 3'd1;
    localparam logic [2:0] DA_SECCNT = 3'd2;
    localparam logic [2:0] DA_LBA0   = 3'd3;
    localparam logic [2:0] DA_LBA1   = 3'd4;
    localparam logic [2:0] DA_LBA2   = 3'd5;
    localparam logic [2:0] DA_DEV    = 3'd6;
    localparam logic [2:0] DA_STAT   = 3'd7;
    localparam logic [2:0] DA_DEVCTL = 3'd6;

    localparam int ST_BSY  = 7;
    localparam int ST_DRDY = 6;
    localparam int ST_DSC  = 4;
    localparam int ST_DRQ  = 3;
    localparam int ST_ERR  = 0;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;
    localparam logic [7:0] ERR_ABRT  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FETCH,
        S_RD_DRQ,
        S_WR_DRQ,
        S_WR_FLUSH
    } ata_state_e;

endpackage

// File: rtl/ata_sector_buf.sv
// One-sector word buffer with a shared auto-increment pointer.
module ata_sector_buf #(
    parameter int BUF_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [15:0]       wdata_i,
    input  logic              inc_i,
    input  logic              pop_i,
    output logic [BUF_AW:0]   ptr_o,
    output logic [15:0]       rdata_o,
    output logic [15:0]       dout_o
);

    logic [15:0]     mem_q [0:(1<<BUF_AW)-1];
    logic [BUF_AW:0] ptr_q, ptr_d;
    logic [15:0]     rdata_q;
    logic [15:0]     dout_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (wr_i || inc_i)
            ptr_d = ptr_q + (BUF_AW+1)'(1);
        else if (pop_i && ptr_q[BUF_AW-1:0] != '1)
            ptr_d = ptr_q + (BUF_AW+1)'(1);
    end

    // rdata_q always holds the word at the current pointer
    always_ff @(posedge clk) begin
        if (wr_i)
            mem_q[ptr_q[BUF_AW-1:0]] <= wdata_i;
        rdata_q <= mem_q[ptr_d[BUF_AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            dout_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (pop_i)
                dout_q <= rdata_q;
        end
    end

    assign ptr_o   = ptr_q;
    assign rdata_o = rdata_q;
    assign dout_o  = dout_q;

endmodule

// File: rtl/ata_target.sv
// ATA PIO drive: task file, sector buffer and READ/WRITE SECTORS engine.
module ata_target #(
    parameter int BUF_AW = 8
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [1:0]  CS_n,
    input  logic [2:0]  DA,
    input  logic        IOR_n,
    input  logic        IOW_n,
    input  logic [15:0] DD_IN,
    output logic [15:0] DD_OUT,
    output logic        DD_OE,
    output logic        INTRQ,
    output logic        BLK_REQ,
    output logic        BLK_WRITE,
    output logic [27:0] BLK_LBA,
    input  logic        BLK_ACK,
    input  logic        BLK_DVALID,
    input  logic [15:0] BLK_DIN,
    input  logic        BLK_DREN,
    output logic [15:0] BLK_DOUT
);
    import ata_pkg::*;

    logic [2:0]  ior_q, iow_q;
    logic [1:0]  rcs_q, wcs_q;
    logic [2:0]  rda_q, wda_q;
    logic [15:0] wdat_q;
    ata_state_e  state_q, state_d;
    logic [7:0]  err_q, err_d, seccnt_q, seccnt_d;
    logic [27:0] lba_q, lba_d;
    logic [3:0]  devhi_q, devhi_d;
    logic [8:0]  rem_q, rem_d;
    logic        nien_q, nien_d, srst_q, srst_d, intrq_q, intrq_d;
    logic        buf_clr, buf_wr, buf_inc, buf_pop, sec_done;
    logic [15:0] buf_wdata, rdata;
    logic [BUF_AW:0] ptr;
    logic        ior_rise, iow_rise, bsy, drq, last;
    logic        cmd_wr, ctl_wr, data_rd, stat_rd;
    logic [7:0]  status, wbyte;

    assign ior_rise = ior_q[1] & ~ior_q[2];
    assign iow_rise = iow_q[1] & ~iow_q[2];
    assign bsy  = srst_q | (state_q == S_RD_FETCH) | (state_q == S_WR_FLUSH);
    assign drq  = (state_q == S_RD_DRQ) | (state_q == S_WR_DRQ);
    assign last = ~ptr[BUF_AW] & (ptr[BUF_AW-1:0] == '1);
    assign wbyte = wdat_q[7:0];

    assign cmd_wr  = iow_rise && wcs_q == CS_CMD && !bsy;
    assign ctl_wr  = iow_rise && wcs_q == CS_CTL && wda_q == DA_DEVCTL;
    assign data_rd = ior_rise && rcs_q == CS_CMD && rda_q == DA_DATA;
    assign stat_rd = ior_rise && rcs_q == CS_CMD && rda_q == DA_STAT;

    always_comb begin
        status          = '0;
        status[ST_BSY]  = bsy;
        status[ST_DRDY] = 1'b1;
        status[ST_DSC]  = 1'b1;
        status[ST_DRQ]  = drq;
        status[ST_ERR]  = |err_q;
    end

    always_comb begin
        DD_OUT = '0;
        if (CS_n == CS_CMD) begin
            case (DA)
                DA_DATA:   DD_OUT = rdata;
                DA_ERR:    DD_OUT = {8'h00, err_q};
                DA_SECCNT: DD_OUT = {8'h00, seccnt_q};
                DA_LBA0:   DD_OUT = {8'h00, lba_q[7:0]};
                DA_LBA1:   DD_OUT = {8'h00, lba_q[15:8]};
                DA_LBA2:   DD_OUT = {8'h00, lba_q[23:16]};
                DA_DEV:    DD_OUT = {8'h00, devhi_q, lba_q[27:24]};
                default:   DD_OUT = {8'h00, status};
            endcase
        end else if (CS_n == CS_CTL && DA == DA_DEVCTL) begin
            DD_OUT = {8'h00, status};
        end
    end

    assign DD_OE     = !IOR_n && (CS_n == CS_CMD || CS_n == CS_CTL);
    assign INTRQ     = intrq_q;
    assign BLK_REQ   = (state_q == S_RD_FETCH) | (state_q == S_WR_FLUSH);
    assign BLK_WRITE = (state_q == S_WR_FLUSH);
    assign BLK_LBA   = lba_q;
    assign buf_wdata = (state_q == S_RD_FETCH) ? BLK_DIN : wdat_q;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        seccnt_d = seccnt_q;
        lba_d    = lba_q;
        devhi_d  = devhi_q;
        rem_d    = rem_q;
        nien_d   = nien_q;
        srst_d   = srst_q;
        intrq_d  = intrq_q;
        buf_clr  = 1'b0;
        buf_wr   = 1'b0;
        buf_inc  = 1'b0;
        buf_pop  = 1'b0;
        sec_done = 1'b0;
        if (stat_rd)
            intrq_d = 1'b0;
        if (cmd_wr) begin
            case (wda_q)
                DA_SECCNT: seccnt_d = wbyte;
                DA_LBA0:   lba_d[7:0] = wbyte;
                DA_LBA1:   lba_d[15:8] = wbyte;
                DA_LBA2:   lba_d[23:16] = wbyte;
                DA_DEV: begin
                    devhi_d = wdat_q[7:4];
                    lba_d[27:24] = wdat_q[3:0];
                end
                default: ;
            endcase
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_wr && wda_q == DA_STAT) begin
                    if (wbyte == CMD_READ || wbyte == CMD_WRITE) begin
                        err_d   = '0;
                        rem_d   = (seccnt_q == 8'd0) ? 9'd256 : {1'b0, seccnt_q};
                        buf_clr = 1'b1;
                        state_d = (wbyte == CMD_READ) ? S_RD_FETCH : S_WR_DRQ;
                    end else begin
                        err_d   = ERR_ABRT;
                        intrq_d = !nien_q;
                    end
                end
            end
            S_RD_FETCH: begin
                buf_wr = BLK_DVALID && !ptr[BUF_AW];
                if (BLK_ACK) begin
                    buf_clr = 1'b1;
                    state_d = S_RD_DRQ;
                    intrq_d = !nien_q;
                end
            end
            S_RD_DRQ: begin
                buf_inc  = data_rd;
                sec_done = data_rd && last;
            end
            S_WR_DRQ: begin
                buf_wr = cmd_wr && wda_q == DA_DATA;
                if (buf_wr && last) begin
                    buf_clr = 1'b1;
                    state_d = S_WR_FLUSH;
                end
            end
            S_WR_FLUSH: begin
                buf_pop  = BLK_DREN;
                sec_done = BLK_ACK;
                if (BLK_ACK)
                    intrq_d = !nien_q;
            end
            default: state_d = S_IDLE;
        endcase
        if (sec_done) begin
            lba_d    = lba_q + 28'd1;
            seccnt_d = seccnt_q - 8'd1;
            rem_d    = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
                state_d = S_IDLE;
            end else begin
                buf_clr = 1'b1;
                state_d = (state_q == S_RD_DRQ) ? S_RD_FETCH : S_WR_DRQ;
            end
        end
        // soft reset wins over any backend ACK in the same cycle
        if (ctl_wr) begin
            nien_d = wdat_q[1];
            srst_d = wdat_q[2];
            if (wdat_q[2] || srst_q) begin
                state_d  = S_IDLE;
                err_d    = '0;
                seccnt_d = 8'd1;
                lba_d    = '0;
                devhi_d  = '0;
                rem_d    = '0;
                intrq_d  = 1'b0;
                buf_clr  = 1'b1;
                buf_wr   = 1'b0;
                buf_inc  = 1'b0;
                buf_pop  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ior_q    <= 3'b111;
            iow_q    <= 3'b111;
            rcs_q    <= 2'b11;
            rda_q    <= '0;
            wcs_q    <= 2'b11;
            wda_q    <= '0;
            wdat_q   <= '0;
            err_q    <= '0;
            seccnt_q <= 8'd1;
            lba_q    <= '0;
            devhi_q  <= '0;
            rem_q    <= '0;
            nien_q   <= 1'b0;
            srst_q   <= 1'b0;
            intrq_q  <= 1'b0;
        end else begin
            ior_q <= {ior_q[1:0], IOR_n};
            iow_q <= {iow_q[1:0], IOW_n};
            if (!IOR_n) begin
                rcs_q <= CS_n;
                rda_q <= DA;
            end
            if (!IOW_n) begin
                wcs_q  <= CS_n;
                wda_q  <= DA;
                wdat_q <= DD_IN;
            end
            err_q    <= err_d;
            seccnt_q <= seccnt_d;
            lba_q    <= lba_d;
            devhi_q  <= devhi_d;
            rem_q    <= rem_d;
            nien_q   <= nien_d;
            srst_q   <= srst_d;
            intrq_q  <= intrq_d;
        end
    end

    ata_sector_buf #(.BUF_AW(BUF_AW)) u_buf (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .clr_i   (buf_clr),
        .wr_i    (buf_wr),
        .wdata_i (buf_wdata),
        .inc_i   (buf_inc),
        .pop_i   (buf_pop),
        .ptr_o   (ptr),
        .rdata_o (rdata),
        .dout_o  (BLK_DOUT)
    );

endmodule

// File: tb/tb_ata_target.sv
// Directed scoreboard bench for the ATA PIO drive model.
module tb_ata_target;

    localparam int NW = 256;
    localparam logic [1:0] CMD = 2'b10;
    localparam logic [1:0] CTL = 2'b01;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic [1:0]  CS_n = 2'b11;
    logic [2:0]  DA = 3'd0;
    logic        IOR_n = 1'b1;
    logic        IOW_n = 1'b1;
    logic [15:0] DD_IN = 16'h0;
    logic [15:0] DD_OUT;
    logic        DD_OE;
    logic        INTRQ;
    logic        BLK_REQ;
    logic        BLK_WRITE;
    logic [27:0] BLK_LBA;
    logic        BLK_ACK = 1'b0;
    logic        BLK_DVALID = 1'b0;
    logic [15:0] BLK_DIN = 16'h0;
    logic        BLK_DREN = 1'b0;
    logic [15:0] BLK_DOUT;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] wq[$];

    always #5 CLK = ~CLK;

    ata_target #(.BUF_AW(8)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .CS_n(CS_n), .DA(DA),
        .IOR_n(IOR_n), .IOW_n(IOW_n), .DD_IN(DD_IN), .DD_OUT(DD_OUT),
        .DD_OE(DD_OE), .INTRQ(INTRQ), .BLK_REQ(BLK_REQ),
        .BLK_WRITE(BLK_WRITE), .BLK_LBA(BLK_LBA), .BLK_ACK(BLK_ACK),
        .BLK_DVALID(BLK_DVALID), .BLK_DIN(BLK_DIN),
        .BLK_DREN(BLK_DREN), .BLK_DOUT(BLK_DOUT)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk(logic [31:0] obs);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty: got %0h want nothing", obs);
        end else begin
            string t;
            logic [31:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    task automatic wr(logic [1:0] cs, logic [2:0] da, logic [15:0] d);
        @(negedge CLK);
        CS_n = cs; DA = da; DD_IN = d; IOW_n = 1'b0;
        repeat (4) @(negedge CLK);
        IOW_n = 1'b1;
        repeat (5) @(negedge CLK);
        CS_n = 2'b11;
    endtask

    task automatic rd(logic [1:0] cs, logic [2:0] da);
        @(negedge CLK);
        CS_n = cs; DA = da; IOR_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk("dd_oe", DD_OE, 1);
        pop_chk({16'h0, DD_OUT});
        IOR_n = 1'b1;
        repeat (5) @(negedge CLK);
        CS_n = 2'b11;
    endtask

    task automatic wait_req(int budget);
        int n = 0;
        while (!BLK_REQ && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("blk_req_wait", BLK_REQ, 1);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] lastw;
        lastw = '0;

        repeat (3) @(negedge CLK);
        chk("rst_intrq", INTRQ, 0);
        chk("rst_req", BLK_REQ, 0);
        chk("rst_oe", DD_OE, 0);
        RESET_n = 1'b1;
        @(negedge CLK);
        push("rst_status", 32'h50); rd(CMD, 3'd7);
        push("rst_seccnt", 32'h01); rd(CMD, 3'd2);

        wr(CMD, 3'd3, 16'h12);
        wr(CMD, 3'd4, 16'h34);
        wr(CMD, 3'd5, 16'h56);
        wr(CMD, 3'd6, 16'hE7);
        push("lba0", 32'h12); rd(CMD, 3'd3);
        push("lba1", 32'h34); rd(CMD, 3'd4);
        push("lba2", 32'h56); rd(CMD, 3'd5);
        push("dev", 32'hE7); rd(CMD, 3'd6);

        wr(CMD, 3'd7, 16'h20);
        wait_req(20);
        chk("rd_blk_write", BLK_WRITE, 0);
        chk("rd_blk_lba", BLK_LBA, 32'h7563412);
        push("fetch_status", 32'hD0); rd(CMD, 3'd7);

        for (int i = 0; i < NW; i++) begin
            @(negedge CLK);
            BLK_DVALID = 1'b1; BLK_DIN = 16'(i);
        end
        @(negedge CLK);
        BLK_DIN = 16'hDEAD;
        @(negedge CLK);
        BLK_DVALID = 1'b0; BLK_ACK = 1'b1;
        @(negedge CLK);
        BLK_ACK = 1'b0;
        @(negedge CLK);
        chk("rd_intrq", INTRQ, 1);
        chk("rd_req_drop", BLK_REQ, 0);
        push("rd_alt", 32'h58); rd(CTL, 3'd6);
        chk("alt_keeps_intrq", INTRQ, 1);
        push("rd_status", 32'h58); rd(CMD, 3'd7);
        chk("stat_clr_intrq", INTRQ, 0);
        for (int i = 0; i < NW; i++) begin
            push("rd_data", 32'(i));
            rd(CMD, 3'd0);
        end
        push("rd_end_status", 32'h50); rd(CMD, 3'd7);
        push("rd_end_lba0", 32'h13); rd(CMD, 3'd3);
        push("rd_end_seccnt", 32'h00); rd(CMD, 3'd2);

        wr(CMD, 3'd2, 16'h02);
        wr(CMD, 3'd3, 16'h20);
        wr(CMD, 3'd7, 16'h30);
        chk("wr_no_intrq", INTRQ, 0);
        push("wr_status", 32'h58); rd(CMD, 3'd7);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NW; i++) begin
                w = 16'(i * 16'h0101) ^ ((s == 0) ? 16'h1234 : 16'hBEEF);
                wq.push_back(w);
                lastw = w;
                wr(CMD, 3'd0, w);
            end
            wait_req(20);
            chk("wr_blk_write", BLK_WRITE, 1);
            chk("wr_blk_lba", BLK_LBA, 32'h7563420 + 32'(s));
            push("flush_status", 32'hD0); rd(CMD, 3'd7);
            for (int i = 0; i <= NW; i++) begin
                @(negedge CLK);
                BLK_DREN = 1'b1;
                @(negedge CLK);
                BLK_DREN = 1'b0;
                if (i < NW)
                    chk("blk_dout", BLK_DOUT, wq.pop_front());
                else
                    chk("blk_dout_past_end", BLK_DOUT, lastw);
            end
            @(negedge CLK);
            BLK_ACK = 1'b1;
            @(negedge CLK);
            BLK_ACK = 1'b0;
            @(negedge CLK);
            chk("wr_ack_intrq", INTRQ, 1);
            chk("wr_ack_req", BLK_REQ, 0);
            if (s == 0) begin
                push("wr_sec2_status", 32'h58); rd(CMD, 3'd7);
                push("wr_sec2_seccnt", 32'h01); rd(CMD, 3'd2);
                push("wr_sec2_lba0", 32'h21); rd(CMD, 3'd3);
            end else begin
                push("wr_end_status", 32'h50); rd(CMD, 3'd7);
                push("wr_end_seccnt", 32'h00); rd(CMD, 3'd2);
                push("wr_end_lba0", 32'h22); rd(CMD, 3'd3);
            end
        end

        wr(CMD, 3'd7, 16'hA1);
        chk("abrt_intrq", INTRQ, 1);
        push("abrt_alt", 32'h51); rd(CTL, 3'd6);
        push("abrt_error", 32'h04); rd(CMD, 3'd1);
        push("abrt_status", 32'h51); rd(CMD, 3'd7);
        chk("abrt_intrq_clr", INTRQ, 0);

        wr(CTL, 3'd6, 16'h02);
        wr(CMD, 3'd7, 16'hA1);
        chk("nien_mask", INTRQ, 0);
        wr(CTL, 3'd6, 16'h00);

        wr(CMD, 3'd2, 16'h01);
        wr(CMD, 3'd7, 16'h20);
        wait_req(20);
        push("cmd_clr_err_status", 32'hD0); rd(CMD, 3'd7);
        push("cmd_clr_err_error", 32'h00); rd(CMD, 3'd1);

        wr(CTL, 3'd6, 16'h04);
        chk("srst_req_drop", BLK_REQ, 0);
        push("srst_alt_bsy", 32'hD0); rd(CTL, 3'd6);
        wr(CTL, 3'd6, 16'h00);
        @(negedge CLK);
        BLK_ACK = 1'b1;
        @(negedge CLK);
        BLK_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        chk("srst_late_ack_req", BLK_REQ, 0);
        chk("srst_late_ack_intrq", INTRQ, 0);
        push("srst_status", 32'h50); rd(CMD, 3'd7);
        push("srst_seccnt", 32'h01); rd(CMD, 3'd2);
        push("srst_lba0", 32'h00); rd(CMD, 3'd3);
        push("srst_dev", 32'h00); rd(CMD, 3'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
